// File: rtl/mem_pkt_buffer.sv
// mem_pkt_buffer: in-order FIFO between the AGEN memory lane and the LSQ.
// Holds up to DEPTH memory packets. stall_o asserts when free entries drop to SLACK.
// overflow_o is sticky. Payload storage is not reset.
// Optional feature: define MEM_PKT_BUFFER_BYPASS_EN for a zero-latency path
// from memPacket_i to lsqPacket_o when the buffer is empty.

package mem_pkt_buffer_pkg;

    localparam int unsigned LSQ_ID_W = 6;
    localparam int unsigned AL_ID_W  = 6;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;

    // Memory packet leaving the AGEN lane
    typedef struct packed {
        logic                valid;
        logic [LSQ_ID_W-1:0] lsqID;
        logic [AL_ID_W-1:0]  alID;
        logic                is_store;
        logic [1:0]          size;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } mem_pkt_t;

endpackage

module mem_pkt_buffer
    import mem_pkt_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SLACK = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  mem_pkt_t                   memPacket_i,
    output logic                       stall_o,
    output mem_pkt_t                   lsqPacket_o,
    input  logic                       lsqReady_i,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic                       overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] STALL_TH = OCC_W'(DEPTH - SLACK);

    mem_pkt_t             mem_q [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 stall_q, stall_d;
    logic                 overflow_q, overflow_d;

    logic                 empty_c;
    logic                 full_c;
    logic                 enq_c;
    logic                 deq_c;

    // Enqueue/dequeue decisions and next-state pointers, occupancy and flags
    always_comb begin
        empty_c    = (occ_q == '0);
        full_c     = (occ_q == OCC_FULL);
        deq_c      = 1'b0;
        enq_c      = 1'b0;
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        overflow_d = overflow_q;

        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            deq_c = !empty_c && lsqReady_i;
`ifdef MEM_PKT_BUFFER_BYPASS_EN
            // An empty buffer with a ready LSQ hands the packet straight through
            enq_c = memPacket_i.valid && (!full_c || deq_c) && !(empty_c && lsqReady_i);
`else
            enq_c = memPacket_i.valid && (!full_c || deq_c);
`endif
            if (memPacket_i.valid && full_c && !deq_c) begin
                overflow_d = 1'b1;
            end
            if (deq_c) begin
                head_d = head_q + PTR_W'(1);
            end
            if (enq_c) begin
                tail_d = tail_q + PTR_W'(1);
            end
            case ({enq_c, deq_c})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end

        stall_d = (occ_d >= STALL_TH);
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage, written at the tail; no reset needed
    always_ff @(posedge clk) begin
        if (enq_c) begin
            mem_q[tail_q] <= memPacket_i;
        end
    end

    // Head entry presentation, qualified by occupancy (plus bypass when enabled)
    always_comb begin
        lsqPacket_o       = mem_q[head_q];
        lsqPacket_o.valid = !empty_c;
`ifdef MEM_PKT_BUFFER_BYPASS_EN
        if (empty_c && memPacket_i.valid && !flush_i) begin
            lsqPacket_o = memPacket_i;
        end
`endif
    end

    assign stall_o     = stall_q;
    assign occupancy_o = occ_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_mem_pkt_buffer.sv
// Directed self-checking bench for mem_pkt_buffer (DEPTH=4, SLACK=1).
module tb_mem_pkt_buffer;
    import mem_pkt_buffer_pkg::*;

    logic       clk;
    logic       reset;
    logic       flush_i;
    mem_pkt_t   memPacket_i;
    logic       stall_o;
    mem_pkt_t   lsqPacket_o;
    logic       lsqReady_i;
    logic [2:0] occupancy_o;
    logic       overflow_o;

    int n_pass  = 0;
    int n_total = 0;

    mem_pkt_buffer #(.DEPTH(4), .SLACK(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush_i),
        .memPacket_i (memPacket_i),
        .stall_o     (stall_o),
        .lsqPacket_o (lsqPacket_o),
        .lsqReady_i  (lsqReady_i),
        .occupancy_o (occupancy_o),
        .overflow_o  (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mem_pkt_t mk(input logic [5:0] lsq, input logic [5:0] al);
        mem_pkt_t p;
        p.valid    = 1'b1;
        p.lsqID    = lsq;
        p.alID     = al;
        p.is_store = lsq[0];
        p.size     = al[1:0];
        p.addr     = 32'h1000_0000 | {20'd0, lsq, al};
        p.data     = 32'hA5A5_0000 | {20'd0, al, lsq};
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        memPacket_i = '0;
        flush_i     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_in(); lsqReady_i = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n_total++; if (occupancy_o !== 3'd0) $display("FAIL reset_occ got %0d want 0", occupancy_o); else n_pass++;
        n_total++; if (lsqPacket_o.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", lsqPacket_o.valid); else n_pass++;
        n_total++; if (stall_o !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_o); else n_pass++;
        n_total++; if (overflow_o !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow_o); else n_pass++;
    endtask

    task automatic test_single();
        mem_pkt_t p;
        p = mk(6'd5, 6'd1);
        memPacket_i = p; lsqReady_i = 1'b1;
        #1;
`ifndef MEM_PKT_BUFFER_BYPASS_EN
        n_total++; if (lsqPacket_o.valid !== 1'b0) $display("FAIL single_no_same_cycle got %b want 0", lsqPacket_o.valid); else n_pass++;
        tick();
        idle_in();
        #1;
        n_total++; if (lsqPacket_o.valid !== 1'b1) $display("FAIL single_valid got %b want 1", lsqPacket_o.valid); else n_pass++;
        n_total++; if (lsqPacket_o.lsqID !== 6'd5) $display("FAIL single_lsqID got %0d want 5", lsqPacket_o.lsqID); else n_pass++;
        n_total++; if (lsqPacket_o !== p) $display("FAIL single_payload got %h want %h", lsqPacket_o, p); else n_pass++;
        tick();
        n_total++; if (occupancy_o !== 3'd0) $display("FAIL single_drained_occ got %0d want 0", occupancy_o); else n_pass++;
        n_total++; if (lsqPacket_o.valid !== 1'b0) $display("FAIL single_drained_valid got %b want 0", lsqPacket_o.valid); else n_pass++;
`else
        tick();
        idle_in();
`endif
    endtask

    task automatic test_fill();
        logic exp_stall [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        lsqReady_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            memPacket_i = mk(6'(i + 1), 6'(i + 30));
            tick();
            n_total++; if (stall_o !== exp_stall[i]) $display("FAIL fill_stall_%0d got %b want %b", i, stall_o, exp_stall[i]); else n_pass++;
        end
        idle_in();
        #1;
        n_total++; if (occupancy_o !== 3'd4) $display("FAIL fill_occ got %0d want 4", occupancy_o); else n_pass++;
        n_total++; if (overflow_o !== 1'b0) $display("FAIL fill_overflow got %b want 0", overflow_o); else n_pass++;
        n_total++; if (lsqPacket_o.lsqID !== 6'd1) $display("FAIL fill_head got %0d want 1", lsqPacket_o.lsqID); else n_pass++;
    endtask

    task automatic test_overflow();
        memPacket_i = mk(6'd9, 6'd9); lsqReady_i = 1'b0;
        tick();
        idle_in();
        n_total++; if (overflow_o !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow_o); else n_pass++;
        n_total++; if (occupancy_o !== 3'd4) $display("FAIL ovf_occ got %0d want 4", occupancy_o); else n_pass++;
        lsqReady_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (lsqPacket_o.valid !== 1'b1 || lsqPacket_o.lsqID !== 6'(i + 1) || lsqPacket_o.alID !== 6'(i + 30))
                $display("FAIL ovf_drain_%0d got v=%b id=%0d al=%0d want v=1 id=%0d al=%0d",
                         i, lsqPacket_o.valid, lsqPacket_o.lsqID, lsqPacket_o.alID, i + 1, i + 30);
            else n_pass++;
            tick();
        end
        n_total++; if (lsqPacket_o.valid !== 1'b0) $display("FAIL ovf_empty_valid got %b want 0", lsqPacket_o.valid); else n_pass++;
        n_total++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow_o); else n_pass++;
        n_total++; if (stall_o !== 1'b0) $display("FAIL ovf_stall_after_drain got %b want 0", stall_o); else n_pass++;
        // reset together with flush clears the sticky flag
        lsqReady_i = 1'b0;
        memPacket_i = mk(6'd40, 6'd40);
        tick();
        reset = 1'b1; flush_i = 1'b1; memPacket_i = '0;
        tick();
        reset = 1'b0; flush_i = 1'b0;
        n_total++; if (overflow_o !== 1'b0) $display("FAIL rstflush_overflow got %b want 0", overflow_o); else n_pass++;
        n_total++; if (occupancy_o !== 3'd0) $display("FAIL rstflush_occ got %0d want 0", occupancy_o); else n_pass++;
        tick();
        n_total++; if (lsqPacket_o.valid !== 1'b0) $display("FAIL rst_midop_valid got %b want 0", lsqPacket_o.valid); else n_pass++;
    endtask

    task automatic test_full_simul();
        logic [5:0] exp_head;
        lsqReady_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            memPacket_i = mk(6'(10 + i), 6'(i));
            tick();
        end
        lsqReady_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            memPacket_i = mk(6'(14 + i), 6'(4 + i));
            exp_head = 6'(10 + i);
            #1;
            n_total++; if (lsqPacket_o.lsqID !== exp_head) $display("FAIL simul_head_%0d got %0d want %0d", i, lsqPacket_o.lsqID, exp_head); else n_pass++;
            tick();
            n_total++; if (occupancy_o !== 3'd4) $display("FAIL simul_occ_%0d got %0d want 4", i, occupancy_o); else n_pass++;
        end
        idle_in();
        n_total++; if (overflow_o !== 1'b0) $display("FAIL simul_overflow got %b want 0", overflow_o); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            exp_head = 6'(13 + i);
            n_total++;
            if (lsqPacket_o.valid !== 1'b1 || lsqPacket_o.lsqID !== exp_head)
                $display("FAIL simul_drain_%0d got v=%b id=%0d want v=1 id=%0d", i, lsqPacket_o.valid, lsqPacket_o.lsqID, exp_head);
            else n_pass++;
            tick();
        end
        n_total++; if (occupancy_o !== 3'd0) $display("FAIL simul_final_occ got %0d want 0", occupancy_o); else n_pass++;
    endtask

    task automatic test_flush();
        lsqReady_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            memPacket_i = mk(6'(20 + i), 6'(20 + i));
            tick();
        end
        idle_in();
        n_total++; if (occupancy_o !== 3'd3) $display("FAIL flush_pre_occ got %0d want 3", occupancy_o); else n_pass++;
        n_total++; if (stall_o !== 1'b1) $display("FAIL flush_pre_stall got %b want 1", stall_o); else n_pass++;
        flush_i = 1'b1; memPacket_i = mk(6'd23, 6'd23); lsqReady_i = 1'b1;
        tick();
        idle_in(); lsqReady_i = 1'b0;
        n_total++; if (occupancy_o !== 3'd0) $display("FAIL flush_occ got %0d want 0", occupancy_o); else n_pass++;
        n_total++; if (lsqPacket_o.valid !== 1'b0) $display("FAIL flush_valid got %b want 0", lsqPacket_o.valid); else n_pass++;
        n_total++; if (stall_o !== 1'b0) $display("FAIL flush_stall got %b want 0", stall_o); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (lsqPacket_o.valid !== 1'b0) $display("FAIL flush_never_seen_%0d got %b want 0", i, lsqPacket_o.valid); else n_pass++;
        end
        memPacket_i = mk(6'd24, 6'd24);
        tick();
        idle_in();
        n_total++; if (lsqPacket_o.valid !== 1'b1 || lsqPacket_o.lsqID !== 6'd24)
            $display("FAIL flush_resume got v=%b id=%0d want v=1 id=24", lsqPacket_o.valid, lsqPacket_o.lsqID);
        else n_pass++;
        lsqReady_i = 1'b1;
        tick();
        lsqReady_i = 1'b0;
    endtask

`ifdef MEM_PKT_BUFFER_BYPASS_EN
    task automatic test_bypass();
        lsqReady_i = 1'b1; memPacket_i = mk(6'd2, 6'd9);
        #1;
        n_total++; if (lsqPacket_o.valid !== 1'b1 || lsqPacket_o.alID !== 6'd9)
            $display("FAIL bypass_same_cycle got v=%b al=%0d want v=1 al=9", lsqPacket_o.valid, lsqPacket_o.alID);
        else n_pass++;
        tick();
        idle_in();
        n_total++; if (occupancy_o !== 3'd0) $display("FAIL bypass_occ got %0d want 0", occupancy_o); else n_pass++;
        lsqReady_i = 1'b0; memPacket_i = mk(6'd3, 6'd11);
        #1;
        n_total++; if (lsqPacket_o.alID !== 6'd11) $display("FAIL bypass_notready_show got %0d want 11", lsqPacket_o.alID); else n_pass++;
        tick();
        idle_in();
        n_total++; if (occupancy_o !== 3'd1) $display("FAIL bypass_notready_enq got %0d want 1", occupancy_o); else n_pass++;
    endtask
`endif

    initial begin
        reset = 1'b1; flush_i = 1'b0; memPacket_i = '0; lsqReady_i = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_overflow();
        test_full_simul();
        test_flush();
`ifdef MEM_PKT_BUFFER_BYPASS_EN
        test_bypass();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
